// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: a small circular queue of {pc, instr} pairs between fetch and decode,
// with valid/ready handshakes on both sides and a flush that drops everything in flight.
module if_id_buffer #(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    input  logic        i_valid,
    output logic        o_if_ready,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc_plus4,
    output logic        o_misaligned,
    output logic        o_valid,
    input  logic        i_id_ready,
    input  logic        i_flush
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [31:0]   r_pc_mem    [DEPTH];
    logic [31:0]   r_instr_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Ready/valid come only from the registered count, so there is no i_* -> o_* path.
    assign o_if_ready = (r_count != FULL_COUNT);
    assign o_valid    = (r_count != '0);
    assign w_push     = i_valid && o_if_ready;
    assign w_pop      = o_valid && i_id_ready;

    assign o_pc         = o_valid ? r_pc_mem[r_rd_ptr] : 32'h0;
    assign o_instr      = o_valid ? r_instr_mem[r_rd_ptr] : NOP_INSTR;
    assign o_pc_plus4   = o_pc + 32'd4;
    assign o_misaligned = o_valid && (o_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; entries are only observed once count covers them.
    always_ff @(posedge clk) begin
        if (w_push && !rst && !i_flush) begin
            r_pc_mem[r_wr_ptr]    <= i_pc;
            r_instr_mem[r_wr_ptr] <= i_instr;
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Testbench for if_id_buffer: directed scenarios plus randomized traffic checked against a
// queue-based reference model of the buffer.
module tb_if_id_buffer;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_pc;
    logic [31:0] i_instr;
    logic        i_valid;
    logic        o_if_ready;
    logic [31:0] o_pc;
    logic [31:0] o_instr;
    logic [31:0] o_pc_plus4;
    logic        o_misaligned;
    logic        o_valid;
    logic        i_id_ready;
    logic        i_flush;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] mq[$];

    if_id_buffer #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_pc         (i_pc),
        .i_instr      (i_instr),
        .i_valid      (i_valid),
        .o_if_ready   (o_if_ready),
        .o_pc         (o_pc),
        .o_instr      (o_instr),
        .o_pc_plus4   (o_pc_plus4),
        .o_misaligned (o_misaligned),
        .o_valid      (o_valid),
        .i_id_ready   (i_id_ready),
        .i_flush      (i_flush)
    );

    always #5 clk = ~clk;

    function automatic logic m_valid();
        return mq.size() != 0;
    endfunction

    function automatic logic m_ready();
        return mq.size() < DEPTH;
    endfunction

    function automatic logic [31:0] m_pc();
        return (mq.size() != 0) ? mq[0][63:32] : 32'h0;
    endfunction

    function automatic logic [31:0] m_instr();
        return (mq.size() != 0) ? mq[0][31:0] : NOP;
    endfunction

    // Advance the model by one clock using the inputs currently applied, then the DUT.
    task automatic tick();
        bit pop;
        bit push;
        if (rst || i_flush) begin
            mq.delete();
        end else begin
            pop  = (mq.size() != 0) && i_id_ready;
            push = i_valid && (mq.size() < DEPTH);
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back({i_pc, i_instr});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b1; i_pc = 32'h40; i_instr = 32'hdeadbeef;
        i_id_ready = 1'b0; i_flush = 1'b0;
        tick();
        tick();
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_checks++; if (o_if_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", o_if_ready); end
        n_checks++; if (o_instr !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h want %h", o_instr, NOP); end
        n_checks++; if (o_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", o_pc); end
        n_checks++; if (o_pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL reset_plus4: got %h want 4", o_pc_plus4); end
        n_checks++; if (o_misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_misaligned: got %b want 0", o_misaligned); end
        rst = 1'b0; i_valid = 1'b0;
        tick();
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_nothing_queued: got %b want 0", o_valid); end
    endtask

    task automatic test_single();
        i_valid = 1'b1; i_pc = 32'h0; i_instr = 32'h00106293; i_id_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", o_valid); end
        n_checks++; if (o_pc !== 32'h0) begin n_fail++; $display("FAIL single_pc: got %h want 0", o_pc); end
        n_checks++; if (o_instr !== 32'h00106293) begin n_fail++; $display("FAIL single_instr: got %h want 00106293", o_instr); end
        n_checks++; if (o_pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL single_plus4: got %h want 4", o_pc_plus4); end
        tick();
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %b want 0", o_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] got[$];
        bit held;
        i_id_ready = 1'b0;
        i_valid = 1'b1; i_pc = 32'h0; i_instr = 32'h11; tick();
        n_checks++; if (o_if_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after1: got %b want 1", o_if_ready); end
        i_pc = 32'h4; i_instr = 32'h22; tick();
        n_checks++; if (o_if_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_after2: got %b want 0", o_if_ready); end
        i_pc = 32'h8; i_instr = 32'h33; tick();
        n_checks++; if (o_if_ready !== 1'b0 || o_pc !== 32'h0) begin
            n_fail++; $display("FAIL bp_hold: ready %b pc %h want ready 0 pc 0", o_if_ready, o_pc);
        end
        i_id_ready = 1'b1;
        held = 1'b1;
        for (int c = 0; c < 10 && got.size() < 3; c++) begin
            if (o_valid && i_id_ready) got.push_back(o_pc);
            held = !(i_valid && m_ready());
            tick();
            if (!held) i_valid = 1'b0;
        end
        n_checks++; if (got.size() != 3) begin n_fail++; $display("FAIL bp_count: got %0d want 3", got.size()); end
        for (int k = 0; k < 3 && k < got.size(); k++) begin
            n_checks++;
            if (got[k] !== 32'(4 * k)) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", k, got[k], 4 * k); end
        end
        i_valid = 1'b0; tick();
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got %b want 0", o_valid); end
    endtask

    task automatic test_flush();
        i_id_ready = 1'b0; i_valid = 1'b1;
        i_pc = 32'h10; i_instr = 32'h44; tick();
        i_pc = 32'h14; i_instr = 32'h55; tick();
        i_pc = 32'h18; i_instr = 32'h66; i_flush = 1'b1; tick();
        i_flush = 1'b0;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", o_valid); end
        n_checks++; if (o_if_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", o_if_ready); end
        i_pc = 32'h0C; i_instr = 32'h77; tick();
        i_valid = 1'b0;
        n_checks++; if (o_valid !== 1'b1 || o_pc !== 32'h0C || o_instr !== 32'h77) begin
            n_fail++; $display("FAIL flush_target: valid %b pc %h instr %h want 1 0000000c 00000077", o_valid, o_pc, o_instr);
        end
        i_id_ready = 1'b1; tick();
    endtask

    task automatic test_wrap();
        logic [31:0] got[$];
        int sent = 0;
        bit acc;
        i_flush = 1'b0;
        for (int c = 0; c < 400 && got.size() < 20; c++) begin
            i_valid    = (sent < 20);
            i_pc       = 32'h100 + 32'(4 * sent);
            i_instr    = 32'hA000 + 32'(sent);
            i_id_ready = 1'(($urandom & 1));
            if (o_valid && i_id_ready) got.push_back(o_pc);
            acc = i_valid && m_ready();
            tick();
            if (acc) sent++;
            n_checks++;
            if (o_valid !== m_valid() || o_pc !== m_pc() || o_instr !== m_instr() || o_if_ready !== m_ready()) begin
                n_fail++;
                $display("FAIL wrap_cycle%0d: valid %b pc %h instr %h rdy %b want %b %h %h %b", c, o_valid, o_pc,
                         o_instr, o_if_ready, m_valid(), m_pc(), m_instr(), m_ready());
            end
        end
        i_valid = 1'b0;
        n_checks++; if (got.size() != 20) begin n_fail++; $display("FAIL wrap_count: got %0d want 20", got.size()); end
        for (int k = 0; k < got.size(); k++) begin
            n_checks++;
            if (got[k] !== 32'h100 + 32'(4 * k)) begin
                n_fail++; $display("FAIL wrap_order[%0d]: got %h want %h", k, got[k], 32'h100 + 32'(4 * k));
            end
        end
        i_id_ready = 1'b1; tick(); tick();
    endtask

    task automatic test_boundary();
        i_id_ready = 1'b0; i_valid = 1'b1; i_pc = 32'hFFFFFFFC; i_instr = 32'h88; tick();
        i_valid = 1'b0;
        n_checks++; if (o_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_plus4: got %h want 0", o_pc_plus4); end
        n_checks++; if (o_misaligned !== 1'b0) begin n_fail++; $display("FAIL aligned_top: got %b want 0", o_misaligned); end
        i_id_ready = 1'b1; tick();
    endtask

    task automatic test_misaligned_simul();
        i_id_ready = 1'b0; i_valid = 1'b1; i_pc = 32'h0000000E; i_instr = 32'h99; tick();
        n_checks++; if (o_misaligned !== 1'b1) begin n_fail++; $display("FAIL misaligned: got %b want 1", o_misaligned); end
        n_checks++; if (o_pc_plus4 !== 32'h12) begin n_fail++; $display("FAIL misaligned_plus4: got %h want 12", o_pc_plus4); end
        i_id_ready = 1'b1; i_pc = 32'h20; i_instr = 32'haa; tick();
        i_valid = 1'b0; i_id_ready = 1'b0;
        n_checks++; if (o_valid !== 1'b1 || o_pc !== 32'h20 || o_instr !== 32'haa) begin
            n_fail++; $display("FAIL simul_head: valid %b pc %h instr %h want 1 00000020 000000aa", o_valid, o_pc, o_instr);
        end
        n_checks++; if (o_if_ready !== 1'b1) begin n_fail++; $display("FAIL simul_count1: ready %b want 1", o_if_ready); end
        n_checks++; if (o_misaligned !== 1'b0) begin n_fail++; $display("FAIL simul_aligned: got %b want 0", o_misaligned); end
        tick();
        n_checks++; if (o_pc !== 32'h20 || o_if_ready !== 1'b1) begin
            n_fail++; $display("FAIL simul_stable: pc %h ready %b want 00000020 1", o_pc, o_if_ready);
        end
        i_id_ready = 1'b1; tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            rst        = ($urandom_range(0, 39) == 0);
            i_flush    = ($urandom_range(0, 9) == 0);
            i_valid    = 1'(($urandom & 1));
            i_id_ready = 1'(($urandom & 1));
            i_pc       = $urandom;
            i_instr    = $urandom;
            tick();
            n_checks++;
            if (o_valid !== m_valid() || o_pc !== m_pc() || o_instr !== m_instr() || o_if_ready !== m_ready() ||
                o_pc_plus4 !== m_pc() + 32'd4 || o_misaligned !== (m_valid() && m_pc() % 4 != 0)) begin
                n_fail++;
                $display("FAIL rand_cycle%0d: valid %b pc %h instr %h rdy %b p4 %h mis %b want %b %h %h %b", c, o_valid,
                         o_pc, o_instr, o_if_ready, o_pc_plus4, o_misaligned, m_valid(), m_pc(), m_instr(), m_ready());
            end
        end
        rst = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_flush();
        test_wrap();
        test_boundary();
        test_misaligned_simul();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
